fa_pipe_seg: RTL and testbench

Parametrised, segment-pipelined ripple adder/subtractor for the FP datapath's mantissa and Taylor-series accumulation paths. Splits a DATA_WIDTH-bit add into NUM_SEG = DATA_WIDTH/SEG_WIDTH segments, one segment per pipeline stage, and registers the inter-segment carry. Sustains one operation per cycle at a clock rate set by a single SEG_WIDTH carry chain. A valid/ready handshake provides full-pipeline backpressure.

---
 rtl/fa_pipe_seg.sv | 182 ++++++++++++++++++
 tb/tb_fa_pipe_seg.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fa_pipe_seg.sv
// fa_pipe_seg: segment-pipelined ripple adder/subtractor with valid/ready backpressure.
// One SEG_WIDTH carry chain per stage; the inter-segment carry is registered.
// Optional feature macro: FA_PIPE_OVF_EN (registered signed-overflow flag on ovf).
module fa_pipe_seg #(
   parameter int unsigned DATA_WIDTH = 48,
   parameter int unsigned SEG_WIDTH  = 24
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic                  cin,
   input  logic                  sub,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] s,
   output logic                  cout,
   output logic                  ovf
);

   localparam int unsigned NUM_SEG = DATA_WIDTH / SEG_WIDTH;

   // Reject configurations that do not split into whole segments
   if (DATA_WIDTH % SEG_WIDTH != 0) begin : g_width_chk
      $error("fa_pipe_seg: DATA_WIDTH must be a multiple of SEG_WIDTH");
   end

   logic                  adv;
   logic [DATA_WIDTH-1:0] fin_sum;
   logic                  fin_c;
   logic                  fin_v;
`ifdef FA_PIPE_OVF_EN
   logic                  fin_a_msb;
   logic                  fin_b_msb;
   logic                  ovf_q, ovf_d;
`endif
   logic [DATA_WIDTH-1:0] s_q, s_d;
   logic                  cout_q, cout_d;
   logic                  out_valid_q, out_valid_d;

   // Whole pipeline moves together; only the output stage can stall it
   assign adv      = !out_valid_q || out_ready;
   assign in_ready = adv;

   for (genvar k = 0; k < NUM_SEG; k++) begin : g_stg
      localparam int unsigned IN_W  = DATA_WIDTH - k * SEG_WIDTH;
      localparam int unsigned SUM_W = (k + 1) * SEG_WIDTH;

      logic [IN_W-1:0]      op_a;
      logic [IN_W-1:0]      op_b;
      logic                 c_in;
      logic                 v_in;
      logic [SEG_WIDTH:0]   seg_res;
      logic [SUM_W-1:0]     sum_all;

      if (k == 0) begin : g_src
         // Stage 0 takes operands straight from the ports; b is inverted for subtract
         always_comb begin
            op_a = a;
            op_b = sub ? ~b : b;
            c_in = sub | cin;
            v_in = in_valid;
         end
         assign sum_all = seg_res[SEG_WIDTH-1:0];
      end else begin : g_src
         // Later stages consume the unconsumed operand bits of the previous stage
         always_comb begin
            op_a = g_stg[k-1].g_reg.a_q;
            op_b = g_stg[k-1].g_reg.b_q;
            c_in = g_stg[k-1].g_reg.c_q;
            v_in = g_stg[k-1].g_reg.v_q;
         end
         assign sum_all = {seg_res[SEG_WIDTH-1:0], g_stg[k-1].g_reg.sum_q};
      end

      // One segment carry chain
      assign seg_res = {1'b0, op_a[SEG_WIDTH-1:0]} + {1'b0, op_b[SEG_WIDTH-1:0]}
                     + (SEG_WIDTH+1)'(c_in);

      if (k < NUM_SEG - 1) begin : g_reg
         localparam int unsigned UP_W = IN_W - SEG_WIDTH;

         logic [SUM_W-1:0] sum_q, sum_d;
         logic [UP_W-1:0]  a_q, a_d;
         logic [UP_W-1:0]  b_q, b_d;
         logic             c_q, c_d;
         logic             v_q, v_d;

         // Next state: shift everything one stage on advance, otherwise hold
         always_comb begin
            sum_d = sum_q;
            a_d   = a_q;
            b_d   = b_q;
            c_d   = c_q;
            v_d   = v_q;
            if (adv) begin
               sum_d = sum_all;
               a_d   = op_a[IN_W-1:SEG_WIDTH];
               b_d   = op_b[IN_W-1:SEG_WIDTH];
               c_d   = seg_res[SEG_WIDTH];
               v_d   = v_in;
            end
         end

         // Intermediate stage registers
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               sum_q <= '0;
               a_q   <= '0;
               b_q   <= '0;
               c_q   <= 1'b0;
               v_q   <= 1'b0;
            end else begin
               sum_q <= sum_d;
               a_q   <= a_d;
               b_q   <= b_d;
               c_q   <= c_d;
               v_q   <= v_d;
            end
         end
      end else begin : g_last
         assign fin_sum = sum_all;
         assign fin_c   = seg_res[SEG_WIDTH];
         assign fin_v   = v_in;
`ifdef FA_PIPE_OVF_EN
         assign fin_a_msb = op_a[IN_W-1];
         assign fin_b_msb = op_b[IN_W-1];
`endif
      end
   end

   // Output stage: load only valid beats so the result holds across bubbles
   always_comb begin
      s_d         = s_q;
      cout_d      = cout_q;
      out_valid_d = out_valid_q;
`ifdef FA_PIPE_OVF_EN
      ovf_d       = ovf_q;
`endif
      if (adv) begin
         out_valid_d = fin_v;
         if (fin_v) begin
            s_d    = fin_sum;
            cout_d = fin_c;
`ifdef FA_PIPE_OVF_EN
            ovf_d  = (fin_a_msb == fin_b_msb) && (fin_sum[DATA_WIDTH-1] != fin_a_msb);
`endif
         end
      end
   end

   // Output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s_q         <= '0;
         cout_q      <= 1'b0;
         out_valid_q <= 1'b0;
`ifdef FA_PIPE_OVF_EN
         ovf_q       <= 1'b0;
`endif
      end else begin
         s_q         <= s_d;
         cout_q      <= cout_d;
         out_valid_q <= out_valid_d;
`ifdef FA_PIPE_OVF_EN
         ovf_q       <= ovf_d;
`endif
      end
   end

   assign s         = s_q;
   assign cout      = cout_q;
   assign out_valid = out_valid_q;
`ifdef FA_PIPE_OVF_EN
   assign ovf       = ovf_q;
`else
   assign ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_fa_pipe_seg.sv
// tb_fa_pipe_seg: directed + randomized bench for fa_pipe_seg with a queue-based reference model.
module tb_fa_pipe_seg;

   localparam int unsigned W  = 48;
   localparam int unsigned SW = 24;
   localparam int unsigned NS = W / SW;
`ifdef FA_PIPE_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
   logic [W-1:0] a, b, s;

   always #5 clk = ~clk;

   fa_pipe_seg #(.DATA_WIDTH(W), .SEG_WIDTH(SW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .s(s), .cout(cout), .ovf(ovf)
   );

   typedef struct packed {
      logic [W-1:0] s;
      logic         c;
      logic         o;
   } res_t;

   res_t         q[$];
   res_t         last = '0;
   int           n_vec = 0;
   int           n_err = 0;
   logic         d_acc, d_ret;
   logic [W-1:0] d_s;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Plain-arithmetic reference: add with carry-in, or a-b with borrow
   function automatic res_t model(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                  input logic ci, input logic sb);
      res_t     r;
      logic [W:0] ext;
      if (sb) begin
         ext = {1'b0, aa} - {1'b0, bb};
         r.c = (aa >= bb);
         r.o = OVF_EN && (aa[W-1] != bb[W-1]) && (ext[W-1] != aa[W-1]);
      end else begin
         ext = {1'b0, aa} + {1'b0, bb} + (W+1)'(ci);
         r.c = ext[W];
         r.o = OVF_EN && (aa[W-1] == bb[W-1]) && (ext[W-1] != aa[W-1]);
      end
      r.s = ext[W-1:0];
      return r;
   endfunction

   // One clock: drive at negedge, check outputs, then book-keep at the posedge
   task automatic step(input logic iv, input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input logic ci, input logic sb, input logic ordy, input logic rn,
                       output logic acc, output logic ret, output logic [W-1:0] ret_s);
      logic exp_rdy;
      @(negedge clk);
      in_valid = iv; a = aa; b = bb; cin = ci; sub = sb; out_ready = ordy; rst_n = rn;
      #1;
      exp_rdy = !out_valid || ordy;
      chk("in_ready", in_ready, exp_rdy);
      ret_s = s;
      if (out_valid) begin
         if (q.size() == 0) begin
            chk("spurious_out", out_valid, 1'b0);
         end else begin
            chk("s", s, q[0].s);
            chk("cout", cout, q[0].c);
            chk("ovf", ovf, q[0].o);
            last = q[0];
         end
      end else begin
         chk("hold_s", s, last.s);
         chk("hold_cout", cout, last.c);
         chk("hold_ovf", ovf, last.o);
      end
      acc = iv && exp_rdy && rn;
      ret = out_valid && ordy && rn;
      @(posedge clk);
      if (!rn) begin
         q.delete();
         last = '0;
      end else begin
         if (ret && q.size() > 0) void'(q.pop_front());
         if (acc) q.push_back(model(aa, bb, ci, sb));
      end
   endtask

   // Single beat on an empty pipe: checks latency and a hand-computed result
   task automatic dir(input string tag, input logic [W-1:0] aa, input logic [W-1:0] bb,
                      input logic ci, input logic sb,
                      input logic [W-1:0] es, input logic ec, input logic eo);
      step(1'b1, aa, bb, ci, sb, 1'b1, 1'b1, d_acc, d_ret, d_s);
      #1;
      chk({tag, "_lat0"}, out_valid, 1'(NS == 1));
      for (int i = 1; i < NS; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, d_acc, d_ret, d_s);
      #1;
      chk({tag, "_valid"}, out_valid, 1'b1);
      chk({tag, "_s"}, s, es);
      chk({tag, "_cout"}, cout, ec);
      chk({tag, "_ovf"}, ovf, OVF_EN & eo);
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, d_acc, d_ret, d_s);
   endtask

   initial begin
      int           idx;
      logic [W-1:0] got[$];
      logic [W-1:0] ra, rb;
      logic         acc, ret;
      logic [W-1:0] rs;

      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);

      // Spec vectors
      dir("seg_carry", 48'h000000FFFFFF, 48'h000000000001, 1'b0, 1'b0, 48'h000001000000, 1'b0, 1'b0);
      dir("full_carry", 48'hFFFFFFFFFFFF, 48'h0, 1'b1, 1'b0, 48'h000000000000, 1'b1, 1'b0);
      dir("sub_neg", 48'd5, 48'd7, 1'b1, 1'b1, 48'hFFFFFFFFFFFE, 1'b0, 1'b0);
      dir("sub_pos", 48'd7, 48'd5, 1'b0, 1'b1, 48'd2, 1'b1, 1'b0);
      dir("ovf_add", 48'h7FFFFFFFFFFF, 48'd1, 1'b0, 1'b0, 48'h800000000000, 1'b0, 1'b1);
      dir("ovf_sub", 48'h800000000000, 48'd1, 1'b0, 1'b1, 48'h7FFFFFFFFFFF, 1'b1, 1'b1);
      dir("no_ovf", 48'd3, 48'd4, 1'b0, 1'b0, 48'd7, 1'b0, 1'b0);

      // Backpressure: four beats, consumer stalls for 3 cycles once results appear
      idx = 0;
      for (int c = 0; c < 40 && !(idx == 4 && q.size() == 0); c++) begin
         step(1'(idx < 4), W'(idx + 1), W'(idx + 1), 1'b0, 1'b0, 1'(!(c >= 2 && c <= 4)), 1'b1,
              acc, ret, rs);
         if (acc) idx++;
         if (ret) got.push_back(rs);
      end
      chk("bp_count", 64'(got.size()), 64'd4);
      for (int k = 0; k < got.size(); k++) chk("bp_result", got[k], W'(2 * (k + 1)));

      // Reset mid-flight, then reset coinciding with an offered beat
      step(1'b1, 48'd1, 48'd2, 1'b0, 1'b0, 1'b1, 1'b1, d_acc, d_ret, d_s);
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, d_acc, d_ret, d_s);
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_s", s, '0);
      chk("rst_in_ready", in_ready, 1'b1);
      step(1'b1, 48'd9, 48'd9, 1'b0, 1'b0, 1'b1, 1'b0, d_acc, d_ret, d_s);
      for (int i = 0; i < 6; i++) begin
         step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, d_acc, d_ret, d_s);
         #1;
         chk("rst_no_result", out_valid, 1'b0);
      end

      // Randomized traffic with random backpressure and corner operands
      for (int i = 0; i < 400; i++) begin
         ra = W'({$urandom(), $urandom()});
         rb = W'({$urandom(), $urandom()});
         case ($urandom_range(0, 7))
            0: ra = '1;
            1: rb = '0;
            2: begin ra = {1'b0, {(W-1){1'b1}}}; rb = W'($urandom_range(0, 3)); end
            3: begin ra = {1'b1, {(W-1){1'b0}}}; rb = W'($urandom_range(0, 3)); end
            default: ;
         endcase
         step(1'($urandom_range(0, 3) != 0), ra, rb, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 7), 1'b1, d_acc, d_ret, d_s);
      end

      // Drain whatever is left
      for (int i = 0; i < 20 && q.size() > 0; i++)
         step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, d_acc, d_ret, d_s);
      chk("drain_empty", 64'(q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
